// File: rtl/mem_responder.sv
// Word-addressed memory target with a request/ready handshake and a fixed number of wait states.
// Each request is latched, then answered after WAIT_STATES cycles. Misaligned, out-of-range and conflicting requests are flagged.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic               fault_q, fault_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               req_fault;
    logic               mem_we;
    logic [31:0]        rd_word;

    // Storage starts zeroed and is deliberately left untouched by reset.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    assign req_fault = (mem_addr[1:0] != 2'b00)
                    || (mem_addr >= ADDR_LIMIT)
                    || (mem_read && mem_write);

    assign rd_word = mem_q[idx_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = mem_addr[IDX_W+1:2];
                    wdata_d = mem_wdata;
                    write_d = mem_write;
                    fault_d = req_fault;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESPOND;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                if (!fault_q) begin
                    if (write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // A reset landing in the response cycle must also suppress the commit.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_ready = (state_q == S_RESPOND);
    assign mem_busy  = (state_q != S_IDLE);
    assign mem_error = mem_ready && fault_q;
    assign mem_rdata = (mem_ready && !fault_q && !write_q) ? rd_word : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (WAIT_STATES 2 and 0) checked against an array model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WS0   = 2;
    localparam int unsigned WS1   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] rdy_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  rd, wr, rdy, busy, err;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];

    logic [31:0] cyc = '0;
    int          total = 0;
    int          passed = 0;
    bit          mon_off [2];

    exp_t        expq [2][$];
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .mem_addr(addr[0]), .mem_read(rd[0]),
        .mem_write(wr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
        .mem_ready(rdy[0]), .mem_busy(busy[0]), .mem_error(err[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .mem_addr(addr[1]), .mem_read(rd[1]),
        .mem_write(wr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
        .mem_ready(rdy[1]), .mem_busy(busy[1]), .mem_error(err[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s dut%0d cyc=%0d actual=0x%08h expected=0x%08h", name, d, cyc, act, exp_v);
    endtask

    function automatic int unsigned ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic bit is_fault(input bit r, input bit w, input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * DEPTH) || (r && w);
    endfunction

    // Monitor: compares every response against the head of the expectation queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d] && !mon_off[d]) begin
                exp_t e;
                logic busy_exp;
                busy_exp = (expq[d].size() != 0) && (cyc >= expq[d][0].rdy_cyc - ws_of(d));
                chk("busy", d, 32'(busy[d]), 32'(busy_exp));
                if (rdy[d]) begin
                    if (expq[d].size() == 0) begin
                        chk("unexpected_ready", d, 32'(rdy[d]), 32'd0);
                    end else begin
                        e = expq[d].pop_front();
                        chk("ready_cycle", d, cyc, e.rdy_cyc);
                        chk("error", d, 32'(err[d]), 32'(e.err));
                        chk("rdata", d, rdata[d], e.rdata);
                    end
                end else begin
                    chk("error_idle", d, 32'(err[d]), 32'd0);
                end
            end
        end
    end

    task automatic issue(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit scr);
        exp_t e;
        bit   seen;
        bit   f;
        f = is_fault(r, w, a);
        if (!f) begin
            if (w) model_mem[d][a >> 2] = wd;
            else   last_rd[d] = model_mem[d][a >> 2];
        end
        e.rdata   = last_rd[d];
        e.err     = f;
        e.rdy_cyc = cyc + 1 + ws_of(d);
        expq[d].push_back(e);
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (rdy[d]) seen = 1;
            else begin
                @(posedge clk); #1;
                if (scr) begin addr[d] = $urandom; wdata[d] = $urandom; end
            end
        end
        if (!seen) chk("ready_timeout", d, 32'd0, 32'd1);
        @(posedge clk); #1;
        rd[d] = 0; wr[d] = 0; addr[d] = $urandom; wdata[d] = $urandom;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write captured, then reset in the second wait cycle: nothing may be committed.
    task automatic reset_abort(input int d, input logic [31:0] a, input logic [31:0] wd);
        mon_off[d] = 1;
        wr[d] = 1; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1; wr[d] = 0;
        @(posedge clk); #1; rst[d] = 1;
        @(posedge clk); #1; rst[d] = 0;
        expq[d].delete();
        last_rd[d] = '0;
        @(negedge clk);
        chk("abort_ready", d, 32'(rdy[d]), 32'd0);
        chk("abort_busy", d, 32'(busy[d]), 32'd0);
        chk("abort_error", d, 32'(err[d]), 32'd0);
        chk("abort_rdata", d, rdata[d], 32'd0);
        mon_off[d] = 0;
        idle(1);
    endtask

    task automatic random_run(input int d, input int n);
        logic [31:0] a;
        int unsigned t;
        bit r, w;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                0: a = (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
                1: a = 4 * DEPTH + 32'($urandom_range(0, 3)) * 4;
                2: a = $urandom | 32'h8000_0000;
                3: a = 4 * DEPTH - 4;
                default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            endcase
            t = $urandom_range(0, 19);
            r = (t == 0) || (t < 10);
            w = (t == 0) || (t >= 10);
            issue(d, r, w, a, $urandom, bit'($urandom_range(0, 1)));
            idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) model_mem[d][i] = '0;
            last_rd[d] = '0;
            mon_off[d] = 0;
            addr[d] = '0;
            wdata[d] = '0;
        end
        rst = 2'b11; rd = '0; wr = '0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, 32'(rdy[d]), 32'd0);
            chk("reset_busy", d, 32'(busy[d]), 32'd0);
            chk("reset_error", d, 32'(err[d]), 32'd0);
            chk("reset_rdata", d, rdata[d], 32'd0);
        end
        @(posedge clk); #1;
        rst = 2'b00;

        issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 0); idle(1);
        issue(0, 1, 0, 32'h10, 32'h0, 0);        idle(1);

        issue(1, 0, 1, 32'h4, 32'h12345678, 0);  idle(1);
        issue(1, 1, 0, 32'h4, 32'h0, 0);         idle(1);
        issue(1, 0, 1, 32'h6, 32'hCAFEF00D, 0);  idle(1);
        issue(1, 1, 0, 32'h400, 32'h0, 0);       idle(1);
        issue(1, 1, 0, 32'h4, 32'h0, 0);         idle(1);

        issue(0, 0, 1, 32'h8, 32'h11112222, 0);  idle(1);
        issue(0, 1, 1, 32'h8, 32'hFFFFFFFF, 0);  idle(1);
        issue(0, 1, 0, 32'h8, 32'h0, 0);         idle(1);

        reset_abort(0, 32'h20, 32'hA5A5A5A5);
        issue(0, 1, 0, 32'h20, 32'h0, 0);        idle(1);

        issue(0, 0, 1, 32'h30, 32'h0BADCAFE, 1); idle(1);
        issue(0, 1, 0, 32'h30, 32'h0, 1);        idle(1);
        issue(1, 0, 1, 32'h3FC, 32'h76543210, 1); idle(1);
        issue(1, 1, 0, 32'h3FC, 32'h0, 1);       idle(1);

        random_run(0, 60);
        random_run(1, 60);

        idle(10);
        for (int d = 0; d < 2; d++) chk("queue_drained", d, 32'(expq[d].size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
